custom_divide: RTL and testbench
================================

CUSTOM_DIVIDE -- requirements
Module: custom_divide

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter ITER, default WIDTH, number of restoring-division iterations.
REQ-003 Port clk, input, 1: clock, all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port clk_en, input, 1: Nios custom-instruction clock enable; when low, all state and outputs SHALL hold.
REQ-006 Port start, input, 1: valid operands are present on dataa/datab (Nios multicycle handshake).
REQ-007 Port n, input, 1: result select, 0 = quotient, 1 = remainder; sampled with start.
REQ-008 Port dataa, input, WIDTH: unsigned dividend.
REQ-009 Port datab, input, WIDTH: unsigned divisor.
REQ-010 Port done, output, 1: single-cycle completion pulse to Nios.
REQ-011 Port result, output, WIDTH: quotient or remainder per latched n.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DIVIDE, FINISH.
REQ-013 IDLE: on an edge with clk_en=1 and start=1, the block SHALL latch dataa, datab and n, clear the partial remainder, load counter=ITER, and go to DIVIDE.
REQ-014 DIVIDE: each enabled edge SHALL perform one restoring step (shift {rem,quo} left 1; if rem>=divisor then rem-=divisor and quo[0]=1) and decrement counter.
REQ-015 DIVIDE SHALL go to FINISH on the edge where counter reaches 0; that same edge SHALL register result (quotient if n=0, remainder if n=1).
REQ-016 FINISH: done SHALL be 1 for exactly one cycle; the next enabled edge SHALL return to IDLE.
REQ-017 Latency: done SHALL rise ITER+1 enabled edges after the edge that sampled start (33 for WIDTH=32).
REQ-018 The remainder path SHALL be WIDTH+1 bits so the compare/subtract never overflows.
REQ-019 start asserted in DIVIDE or FINISH SHALL be ignored; operands are not re-latched.
REQ-020 Divisor 0 SHALL produce quotient all-ones and remainder=dividend with the normal latency; no error flag.
REQ-021 clk_en low SHALL freeze state, counter, done and result; done stays high while frozen in FINISH.
REQ-022 result SHALL hold its last value from FINISH until the next completion.
REQ-023 done SHALL never be asserted outside FINISH.

Reset
REQ-024 reset SHALL, immediately and regardless of clk_en, force state=IDLE, done=0, result=0, counter=0, internal operands=0.
REQ-025 reset mid-operation SHALL abandon the division; no done pulse for it.
REQ-026 The first start after reset release SHALL behave as from IDLE.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE, DIVIDE, FINISH) and the default WIDTH/ITER constants, shared with custom_multiply-family blocks.
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring iteration (inputs rem, quo, divisor; outputs next rem, next quo).
REQ-029 All registers SHALL reside in custom_divide; div_step SHALL contain no state.

Verification
REQ-030 dataa=100, datab=7, n=0 -> done 33 edges after start, result=14; repeat with n=1 -> result=2.
REQ-031 dataa=0xFFFFFFFF, datab=1, n=0 -> result=0xFFFFFFFF; n=1 -> result=0.
REQ-032 dataa=1234, datab=0 -> n=0 result=0xFFFFFFFF, n=1 result=1234, latency 33.
REQ-033 dataa=5, datab=9, n=0 -> result=0; clk_en low for 10 cycles mid-operation -> done 43 edges after start, result unchanged.
REQ-034 start re-asserted with new operands at edge 5 of a busy operation -> ignored, first result correct, single done pulse.
REQ-035 reset asserted at edge 10 of an operation -> done=0 and result=0 immediately, no done pulse; next start completes normally.

Source files
------------

// File: rtl/custom_divide_pkg.sv
// -----------------------------------------------------------------------------
// custom_divide_pkg
// Shared definitions for the Nios custom-instruction arithmetic family
// (custom_divide, custom_multiply and relatives).
//   - state_t        : three-state multicycle handshake FSM encoding
//   - DEFAULT_WIDTH  : default operand/result width
//   - DEFAULT_ITER   : default iteration count (one step per result bit)
// -----------------------------------------------------------------------------
package custom_divide_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_ITER  = DEFAULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/custom_divide_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One purely combinational restoring-division iteration.
// The {rem, quo} pair is shifted left by one bit, the top quotient bit moving
// into the partial remainder. If the shifted remainder is at least the divisor
// the divisor is subtracted and a 1 enters the quotient LSB, otherwise a 0.
// Ports:
//   rem      [WIDTH:0]   : current partial remainder (one guard bit)
//   quo      [WIDTH-1:0] : current quotient / remaining dividend bits
//   divisor  [WIDTH-1:0] : unsigned divisor
//   rem_next [WIDTH:0]   : partial remainder after this step
//   quo_next [WIDTH-1:0] : quotient after this step
// -----------------------------------------------------------------------------
module div_step
    import custom_divide_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:1] quo_shift;
    logic             fits;
    logic             unused_rem_msb;

    // The incoming remainder is always below the divisor, so its guard bit is
    // zero and dropping it in the shift loses nothing.
    assign unused_rem_msb = rem[WIDTH];
    assign shifted        = {rem[WIDTH-1:0], quo[WIDTH-1]};

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_quo_shift
            assign quo_shift[gi] = quo[gi-1];
        end
    endgenerate

    // Compare at WIDTH+1 bits so a shifted remainder that exceeds WIDTH bits
    // still compares and subtracts correctly.
    assign fits     = (shifted >= {1'b0, divisor});
    assign rem_next = fits ? (shifted - {1'b0, divisor}) : shifted;
    assign quo_next = {quo_shift, fits};

endmodule

// File: rtl/custom_divide.sv
// -----------------------------------------------------------------------------
// custom_divide
// Nios II multicycle custom instruction: unsigned restoring divider.
// A start pulse latches the operands and the result select; ITER restoring
// steps follow, then the selected result is registered and done pulses for
// one enabled cycle. Division by zero is not trapped: it naturally yields an
// all-ones quotient and a remainder equal to the dividend.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high reset
//   clk_en  : custom-instruction clock enable; everything holds while low
//   start   : operands valid on dataa/datab (ignored while busy)
//   n       : result select, 0 = quotient, 1 = remainder (sampled with start)
//   dataa   : unsigned dividend
//   datab   : unsigned divisor
//   done    : completion pulse, high only in FINISH
//   result  : quotient or remainder, held until the next completion
// -----------------------------------------------------------------------------
module custom_divide
    import custom_divide_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic             n,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (ITER < 1) ? 1 : $clog2(ITER + 1);

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [WIDTH:0]   rem_reg,     rem_next;
    logic [WIDTH-1:0] quo_reg,     quo_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic             n_reg,       n_next;
    logic [WIDTH-1:0] result_reg,  result_next;
    logic             done_reg,    done_next;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Next-state and datapath decode.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        divisor_next = divisor_reg;
        n_next       = n_reg;
        result_next  = result_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    quo_next     = dataa;
                    divisor_next = datab;
                    n_next       = n;
                    rem_next     = '0;
                    counter_next = CNT_W'(ITER);
                    state_next   = DIVIDE;
                end
            end

            DIVIDE: begin
                // The edge after the last step commits the result; this
                // gives done ITER+1 enabled edges after the start edge.
                if (counter_reg == '0) begin
                    result_next = n_reg ? rem_reg[WIDTH-1:0] : quo_reg;
                    done_next   = 1'b1;
                    state_next  = FINISH;
                end else begin
                    rem_next     = step_rem;
                    quo_next     = step_quo;
                    counter_next = counter_reg - CNT_W'(1);
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All state lives here. clk_en gates every update so a stalled
    // instruction freezes completely, including a pending done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            n_reg       <= 1'b0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
        end else if (clk_en) begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            divisor_reg <= divisor_next;
            n_reg       <= n_next;
            result_reg  <= result_next;
            done_reg    <= done_next;
        end
    end

    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_custom_divide.sv
// -----------------------------------------------------------------------------
// tb_custom_divide
// Self-checking bench for custom_divide (WIDTH=32, ITER=32). Expected results
// come from plain integer division; latency is counted in enabled edges.
// -----------------------------------------------------------------------------
module tb_custom_divide;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int LIMIT = 300;

    logic             clk;
    logic             reset;
    logic             clk_en;
    logic             start;
    logic             n;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks   = 0;
    int failures = 0;

    custom_divide #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned division with divide-by-zero giving all-ones/dividend.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sel);
        if (b == 0) return sel ? a : {WIDTH{1'b1}};
        return sel ? (a % b) : (a / b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation. stall_len>0 drops clk_en for that many edges starting
    // at edge stall_at; restart_at>0 re-asserts start with junk operands at that
    // edge; hold_fin freezes the FINISH cycle for a few edges.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sel, input int stall_at, input int stall_len,
                          input int restart_at, input bit hold_fin, input int exp_total);
        int edges;
        int enabled;
        bit seen;
        logic [WIDTH-1:0] exp_res;
        exp_res = model(a, b, sel);
        dataa  = a;
        datab  = b;
        n      = sel;
        start  = 1'b1;
        clk_en = 1'b1;
        tick();
        start = 1'b0;
        edges   = 0;
        enabled = 0;
        seen    = 1'b0;
        while (!seen && edges < LIMIT) begin
            clk_en = !(stall_len > 0 && (edges + 1) >= stall_at && (edges + 1) < stall_at + stall_len);
            if ((edges + 1) == restart_at) begin
                start = 1'b1;
                dataa = $urandom;
                datab = $urandom_range(1, 50);
                n     = ~sel;
            end else begin
                start = 1'b0;
            end
            tick();
            edges++;
            if (clk_en) enabled++;
            if (done) seen = 1'b1;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        check("timeout", {63'd0, seen}, 64'd1);
        check("latency", 64'(enabled), 64'(ITER + 1));
        if (exp_total > 0) check("total_edges", 64'(edges), 64'(exp_total));
        check("result", 64'(result), 64'(exp_res));
        if (hold_fin) begin
            clk_en = 1'b0;
            repeat (3) begin
                tick();
                check("done_frozen", {63'd0, done}, 64'd1);
            end
            clk_en = 1'b1;
        end
        tick();
        check("done_pulse", {63'd0, done}, 64'd0);
        check("result_hold", 64'(result), 64'(exp_res));
        $display("op a=0x%08h b=0x%08h n=%0d result=0x%08h exp=0x%08h edges=%0d",
                 a, b, sel, result, exp_res, edges);
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b0;
        n      = 1'b0;
        dataa  = '0;
        datab  = '0;
        #1;
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", 64'(result), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Directed vectors.
        run_op(32'd100, 32'd7, 1'b0, 0, 0, 0, 1'b0, ITER + 1);
        run_op(32'd100, 32'd7, 1'b1, 0, 0, 0, 1'b0, ITER + 1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0, 0, 0, 1'b0, 0);
        run_op(32'd1234, 32'd0, 1'b0, 0, 0, 0, 1'b0, ITER + 1);
        run_op(32'd1234, 32'd0, 1'b1, 0, 0, 0, 1'b0, ITER + 1);
        run_op(32'd5, 32'd9, 1'b0, 12, 10, 0, 1'b0, ITER + 11);
        run_op(32'd100, 32'd7, 1'b0, 0, 0, 5, 1'b0, ITER + 1);
        run_op(32'd99, 32'd10, 1'b1, 0, 0, 0, 1'b1, 0);

        // Reset at edge 10 of an operation: outputs clear at once, no done.
        begin
            int edges;
            bit any_done;
            dataa = 32'd1000;
            datab = 32'd3;
            n     = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (10) tick();
            reset = 1'b1;
            #1;
            check("rst_mid_done", {63'd0, done}, 64'd0);
            check("rst_mid_result", 64'(result), 64'd0);
            tick();
            reset = 1'b0;
            any_done = 1'b0;
            edges = 0;
            while (edges < 40) begin
                tick();
                edges++;
                if (done) any_done = 1'b1;
            end
            check("rst_no_done", {63'd0, any_done}, 64'd0);
            $display("op reset mid-operation result=0x%08h done=%0d", result, done);
        end
        run_op(32'd1000, 32'd3, 1'b0, 0, 0, 0, 1'b0, ITER + 1);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            int sa;
            int sl;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = $urandom >> $urandom_range(0, 31);
                2:       b = a + $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            sa = $urandom_range(1, 30);
            sl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            run_op(a, b, 1'($urandom_range(0, 1)), sa, sl,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0,
                   1'($urandom_range(0, 1)), ITER + 1 + sl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
